// File: rtl/bresenham_line_plotter.sv
// Bresenham line rasteriser feeding vga_adapter: latches two endpoints and a
// colour on start, then emits one pixel per clock until the far endpoint is
// drawn. Off-screen pixels are stepped through with plot held low.
module bresenham_line_plotter #(
    parameter int X_WIDTH      = 8,
    parameter int Y_WIDTH      = 7,
    parameter int COLOUR_WIDTH = 3,
    parameter int X_MAX        = 159,
    parameter int Y_MAX        = 119
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [X_WIDTH-1:0]      x0,
    input  logic [X_WIDTH-1:0]      x1,
    input  logic [Y_WIDTH-1:0]      y0,
    input  logic [Y_WIDTH-1:0]      y1,
    input  logic [COLOUR_WIDTH-1:0] colour_in,
    output logic [X_WIDTH-1:0]      x,
    output logic [Y_WIDTH-1:0]      y,
    output logic [COLOUR_WIDTH-1:0] colour,
    output logic                    plot,
    output logic                    busy,
    output logic                    done
);

    // Three guard bits keep 2*err and the signed deltas from overflowing.
    localparam int W = ((X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH) + 3;

    localparam logic [X_WIDTH-1:0]  X_LIM = X_MAX[X_WIDTH-1:0];
    localparam logic [Y_WIDTH-1:0]  Y_LIM = Y_MAX[Y_WIDTH-1:0];
    localparam logic [X_WIDTH-1:0]  X_ONE = 1;
    localparam logic [Y_WIDTH-1:0]  Y_ONE = 1;
    localparam logic signed [W-1:0] ZERO  = '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_DRAW,
        S_DONE
    } state_t;

    state_t state;

    logic [X_WIDTH-1:0]  x0_r, x1_r;
    logic [Y_WIDTH-1:0]  y0_r, y1_r;
    logic signed [W-1:0] dx_r, dy_r, err_r;
    logic                sx_neg, sy_neg;

    logic signed [W-1:0] dx_s, dy_s;
    logic signed [W-1:0] e2, err_nx;
    logic                step_x, step_y;
    logic [X_WIDTH-1:0]  cx_nx;
    logic [Y_WIDTH-1:0]  cy_nx;

    function automatic logic signed [W-1:0] abs_diff(input logic signed [W-1:0] a,
                                                     input logic signed [W-1:0] b);
        logic signed [W-1:0] d;
        d = a - b;
        return (d < ZERO) ? -d : d;
    endfunction

    function automatic logic on_screen(input logic [X_WIDTH-1:0] px,
                                       input logic [Y_WIDTH-1:0] py);
        return (px <= X_LIM) && (py <= Y_LIM);
    endfunction

    // Setup terms (deltas) and one Bresenham step from the current point.
    always_comb begin
        dx_s   = abs_diff($signed({{(W-X_WIDTH){1'b0}}, x1_r}),
                          $signed({{(W-X_WIDTH){1'b0}}, x0_r}));
        dy_s   = -abs_diff($signed({{(W-Y_WIDTH){1'b0}}, y1_r}),
                           $signed({{(W-Y_WIDTH){1'b0}}, y0_r}));
        e2     = err_r <<< 1;
        step_x = (e2 >= dy_r);
        step_y = (e2 <= dx_r);
        err_nx = err_r + (step_x ? dy_r : ZERO) + (step_y ? dx_r : ZERO);
        cx_nx  = x;
        cy_nx  = y;
        if (step_x) cx_nx = sx_neg ? (x - X_ONE) : (x + X_ONE);
        if (step_y) cy_nx = sy_neg ? (y - Y_ONE) : (y + Y_ONE);
    end

    // Control FSM; x/y double as the current point so outputs are registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= S_IDLE;
            x      <= '0;
            y      <= '0;
            colour <= '0;
            plot   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    plot <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        x0_r   <= x0;
                        x1_r   <= x1;
                        y0_r   <= y0;
                        y1_r   <= y1;
                        colour <= colour_in;
                        busy   <= 1'b1;
                        state  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    dx_r   <= dx_s;
                    dy_r   <= dy_s;
                    err_r  <= dx_s + dy_s;
                    sx_neg <= !(x0_r < x1_r);
                    sy_neg <= !(y0_r < y1_r);
                    x      <= x0_r;
                    y      <= y0_r;
                    plot   <= on_screen(x0_r, y0_r);
                    state  <= S_DRAW;
                end
                S_DRAW: begin
                    if (x == x1_r && y == y1_r) begin
                        plot  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        x     <= cx_nx;
                        y     <= cy_nx;
                        err_r <= err_nx;
                        plot  <= on_screen(cx_nx, cy_nx);
                    end
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bresenham_line_plotter.sv
// Directed bench for bresenham_line_plotter: each scenario task draws a line,
// records the per-cycle outputs and compares them with hand-derived pixels.
module tb_bresenham_line_plotter;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] x0 = '0, x1 = '0;
    logic [6:0] y0 = '0, y1 = '0;
    logic [2:0] colour_in = '0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, busy, done;

    int checks = 0;
    int errors = 0;

    // Per-cycle record, index k = cycles after the accepting edge.
    logic       plot_h [0:63];
    logic       busy_h [0:63];
    logic       done_h [0:63];
    logic [7:0] x_h    [0:63];
    logic [6:0] y_h    [0:63];
    int         done_k;

    bresenham_line_plotter dut (
        .clock(clock), .reset(reset), .start(start),
        .x0(x0), .x1(x1), .y0(y0), .y1(y1), .colour_in(colour_in),
        .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    task automatic do_start(input logic [7:0] ax0, input logic [6:0] ay0,
                            input logic [7:0] ax1, input logic [6:0] ay1,
                            input logic [2:0] col);
        @(negedge clock);
        x0 = ax0; y0 = ay0; x1 = ax1; y1 = ay1; colour_in = col;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    // Record outputs until done (plus one cycle) or the limit expires.
    // Optionally pulse an extra start or a reset after sampling cycle evt_k.
    task automatic capture(input int limit, input int start_k, input int reset_k);
        done_k = 0;
        for (int k = 0; k < 64; k++) begin
            plot_h[k] = 1'b0; busy_h[k] = 1'b0; done_h[k] = 1'b0;
            x_h[k] = '0; y_h[k] = '0;
        end
        for (int k = 1; k <= limit; k++) begin
            @(negedge clock);
            plot_h[k] = plot; busy_h[k] = busy; done_h[k] = done;
            x_h[k] = x; y_h[k] = y;
            start = (k == start_k);
            if (k == start_k) begin
                x0 = 8'd50; y0 = 7'd50; x1 = 8'd60; y1 = 7'd60; colour_in = 3'd5;
            end
            reset = (k == reset_k);
            if (done_k != 0) break;
            if (done) done_k = k;
        end
        start = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        checks++; if (plot !== 1'b0) begin errors++; $display("FAIL reset_plot got %b want 0", plot); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (x !== 8'd0 || y !== 7'd0) begin errors++; $display("FAIL reset_xy got %0d,%0d want 0,0", x, y); end
        checks++; if (colour !== 3'd0) begin errors++; $display("FAIL reset_colour got %0d want 0", colour); end
        reset = 1'b0;
    endtask

    task automatic test_horizontal;
        int n;
        do_start(8'd0, 7'd0, 8'd4, 7'd0, 3'b111);
        capture(40, 0, 0);
        checks++; if (busy_h[1] !== 1'b1 || plot_h[1] !== 1'b0) begin errors++; $display("FAIL horiz_setup busy=%b plot=%b want 1,0", busy_h[1], plot_h[1]); end
        for (int k = 2; k <= 6; k++) begin
            checks++;
            if (plot_h[k] !== 1'b1 || x_h[k] !== 8'(k-2) || y_h[k] !== 7'd0) begin
                errors++; $display("FAIL horiz_px%0d got plot=%b (%0d,%0d) want 1 (%0d,0)", k, plot_h[k], x_h[k], y_h[k], k-2);
            end
        end
        n = 0;
        for (int k = 1; k <= 40; k++) if (plot_h[k] === 1'b1) n++;
        checks++; if (n != 5) begin errors++; $display("FAIL horiz_count got %0d want 5", n); end
        checks++; if (done_k != 7) begin errors++; $display("FAIL horiz_done_cycle got %0d want 7", done_k); end
        checks++; if (busy_h[8] !== 1'b0 || done_h[8] !== 1'b0) begin errors++; $display("FAIL horiz_idle busy=%b done=%b want 0,0", busy_h[8], done_h[8]); end
        checks++; if (colour !== 3'b111) begin errors++; $display("FAIL horiz_colour got %0d want 7", colour); end
    endtask

    task automatic test_steep;
        logic [7:0] ex [0:6];
        logic [6:0] ey [0:6];
        ex = '{8'd2, 8'd2, 8'd3, 8'd3, 8'd3, 8'd4, 8'd4};
        ey = '{7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd6, 7'd7};
        do_start(8'd2, 7'd1, 8'd4, 7'd7, 3'd1);
        capture(40, 0, 0);
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (plot_h[i+2] !== 1'b1 || x_h[i+2] !== ex[i] || y_h[i+2] !== ey[i]) begin
                errors++; $display("FAIL steep_px%0d got plot=%b (%0d,%0d) want 1 (%0d,%0d)", i, plot_h[i+2], x_h[i+2], y_h[i+2], ex[i], ey[i]);
            end
        end
        checks++; if (done_k != 9) begin errors++; $display("FAIL steep_done_cycle got %0d want 9", done_k); end
    endtask

    task automatic test_reversed_and_point;
        do_start(8'd4, 7'd0, 8'd0, 7'd0, 3'd2);
        capture(40, 0, 0);
        for (int k = 2; k <= 6; k++) begin
            checks++;
            if (plot_h[k] !== 1'b1 || x_h[k] !== 8'(6-k) || y_h[k] !== 7'd0) begin
                errors++; $display("FAIL rev_px%0d got plot=%b (%0d,%0d) want 1 (%0d,0)", k, plot_h[k], x_h[k], y_h[k], 6-k);
            end
        end
        checks++; if (done_k != 7) begin errors++; $display("FAIL rev_done_cycle got %0d want 7", done_k); end

        do_start(8'd9, 7'd9, 8'd9, 7'd9, 3'd6);
        capture(40, 0, 0);
        checks++; if (plot_h[2] !== 1'b1 || x_h[2] !== 8'd9 || y_h[2] !== 7'd9) begin errors++; $display("FAIL point_px got plot=%b (%0d,%0d) want 1 (9,9)", plot_h[2], x_h[2], y_h[2]); end
        checks++; if (done_k != 3) begin errors++; $display("FAIL point_done_cycle got %0d want 3", done_k); end
        repeat (3) @(negedge clock);
        checks++; if (colour !== 3'd6) begin errors++; $display("FAIL point_colour_hold got %0d want 6", colour); end
    endtask

    task automatic test_clipping;
        do_start(8'd158, 7'd0, 8'd161, 7'd0, 3'd3);
        capture(40, 0, 0);
        checks++; if (plot_h[2] !== 1'b1 || x_h[2] !== 8'd158) begin errors++; $display("FAIL clip_158 got plot=%b x=%0d want 1 158", plot_h[2], x_h[2]); end
        checks++; if (plot_h[3] !== 1'b1 || x_h[3] !== 8'd159) begin errors++; $display("FAIL clip_159 got plot=%b x=%0d want 1 159", plot_h[3], x_h[3]); end
        checks++; if (plot_h[4] !== 1'b0 || x_h[4] !== 8'd160 || busy_h[4] !== 1'b1) begin errors++; $display("FAIL clip_160 got plot=%b x=%0d busy=%b want 0 160 1", plot_h[4], x_h[4], busy_h[4]); end
        checks++; if (plot_h[5] !== 1'b0 || x_h[5] !== 8'd161) begin errors++; $display("FAIL clip_161 got plot=%b x=%0d want 0 161", plot_h[5], x_h[5]); end
        checks++; if (done_k != 6) begin errors++; $display("FAIL clip_done_cycle got %0d want 6", done_k); end
    endtask

    task automatic test_ignored_start;
        do_start(8'd10, 7'd5, 8'd13, 7'd5, 3'd2);
        capture(40, 3, 0);
        for (int k = 2; k <= 5; k++) begin
            checks++;
            if (plot_h[k] !== 1'b1 || x_h[k] !== 8'(k+8) || y_h[k] !== 7'd5) begin
                errors++; $display("FAIL ign_px%0d got plot=%b (%0d,%0d) want 1 (%0d,5)", k, plot_h[k], x_h[k], y_h[k], k+8);
            end
        end
        checks++; if (done_k != 6) begin errors++; $display("FAIL ign_done_cycle got %0d want 6", done_k); end
        checks++; if (colour !== 3'd2) begin errors++; $display("FAIL ign_colour got %0d want 2", colour); end
        repeat (4) @(negedge clock);
        checks++; if (busy !== 1'b0 || plot !== 1'b0) begin errors++; $display("FAIL ign_no_second_line busy=%b plot=%b want 0,0", busy, plot); end
    endtask

    task automatic test_reset_mid_line;
        int n;
        do_start(8'd0, 7'd0, 8'd9, 7'd0, 3'd4);
        capture(16, 0, 4);
        checks++; if (plot_h[4] !== 1'b1 || x_h[4] !== 8'd2) begin errors++; $display("FAIL rst_pre got plot=%b x=%0d want 1 2", plot_h[4], x_h[4]); end
        checks++; if (plot_h[5] !== 1'b0 || busy_h[5] !== 1'b0 || x_h[5] !== 8'd0 || y_h[5] !== 7'd0) begin
            errors++; $display("FAIL rst_after got plot=%b busy=%b (%0d,%0d) want 0 0 (0,0)", plot_h[5], busy_h[5], x_h[5], y_h[5]);
        end
        n = 0;
        for (int k = 1; k <= 16; k++) if (done_h[k] === 1'b1) n++;
        checks++; if (n != 0) begin errors++; $display("FAIL rst_no_done got %0d pulses want 0", n); end

        do_start(8'd1, 7'd1, 8'd3, 7'd2, 3'd5);
        capture(40, 0, 0);
        checks++; if (plot_h[2] !== 1'b1 || x_h[2] !== 8'd1 || y_h[2] !== 7'd1) begin errors++; $display("FAIL rst_next_px0 got plot=%b (%0d,%0d) want 1 (1,1)", plot_h[2], x_h[2], y_h[2]); end
        checks++; if (plot_h[3] !== 1'b1 || x_h[3] !== 8'd2 || y_h[3] !== 7'd2) begin errors++; $display("FAIL rst_next_px1 got plot=%b (%0d,%0d) want 1 (2,2)", plot_h[3], x_h[3], y_h[3]); end
        checks++; if (plot_h[4] !== 1'b1 || x_h[4] !== 8'd3 || y_h[4] !== 7'd2) begin errors++; $display("FAIL rst_next_px2 got plot=%b (%0d,%0d) want 1 (3,2)", plot_h[4], x_h[4], y_h[4]); end
        checks++; if (done_k != 5) begin errors++; $display("FAIL rst_next_done_cycle got %0d want 5", done_k); end
    endtask

    initial begin
        test_reset;
        test_horizontal;
        test_steep;
        test_reversed_and_point;
        test_clipping;
        test_ignored_start;
        test_reset_mid_line;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
